// File: rtl/issue_pkg.sv
// Shared types and constants for the dual-issue steering stage.
// Holds the decoded instruction bundle carried from decode into execute,
// the opcode constants that identify memory operations, the steering FSM
// state type and the instruction classification helpers.
package issue_pkg;

    localparam int ISSUE_XLEN = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [ISSUE_XLEN-1:0] RD1;
        logic [ISSUE_XLEN-1:0] RD2;
        logic [ISSUE_XLEN-1:0] Extimm;
        logic                  RegWrite;
        logic [1:0]            ResultSrc;
        logic [2:0]            MemWrite;
        logic [2:0]            MemRead;
        logic                  Jump;
        logic                  Branch;
        logic [4:0]            AluControl;
        logic                  mux2;
        logic                  mux3;
        logic                  mux4;
        logic [4:0]            RS1;
        logic [4:0]            RS2;
        logic [4:0]            Rd;
        logic [6:0]            opcode;
        logic [ISSUE_XLEN-1:0] PC;
        logic [ISSUE_XLEN-1:0] PCPlus4;
    } id_bundle_t;

    typedef enum logic {
        ST_PAIR  = 1'b0,
        ST_SPLIT = 1'b1
    } steer_state_t;

    // Loads and stores can only execute on lane 1.
    function automatic logic is_mem(input id_bundle_t b);
        return (b.opcode == OPC_LOAD) || (b.opcode == OPC_STORE);
    endfunction

    // Branches and jumps can only execute on lane 0.
    function automatic logic is_ctrl(input id_bundle_t b);
        return b.Jump || b.Branch;
    endfunction

endpackage

// File: rtl/pair_check.sv
// Combinational pair analysis for the issue steering stage.
// Ports:
//   slot0, slot1  - decoded bundles, slot0 older in program order
//   valid         - per-slot valid (bit 0 = slot0)
//   conflict      - both valid and the pair must issue over two cycles
//   swap          - both valid, no conflict, older goes to lane 1
//   single_lane   - lane each slot takes when issued alone (bit k = slot k,
//                   1 = lane 1)
module pair_check
    import issue_pkg::*;
(
    input  id_bundle_t slot0,
    input  id_bundle_t slot1,
    input  logic [1:0] valid,
    output logic       conflict,
    output logic       swap,
    output logic [1:0] single_lane
);

    logic mem0, mem1, ctrl0, ctrl1;
    logic raw, waw;

    assign mem0  = is_mem(slot0);
    assign mem1  = is_mem(slot1);
    assign ctrl0 = is_ctrl(slot0);
    assign ctrl1 = is_ctrl(slot1);

    // Source match is conservative: the younger's rs fields are compared
    // even when the instruction does not actually read that operand.
    assign raw = slot0.RegWrite && (slot0.Rd != 5'd0) &&
                 ((slot1.RS1 == slot0.Rd) || (slot1.RS2 == slot0.Rd));

    assign waw = slot0.RegWrite && slot1.RegWrite &&
                 (slot0.Rd != 5'd0) && (slot0.Rd == slot1.Rd);

    assign conflict = (&valid) && ((mem0 && mem1) || (ctrl0 && ctrl1) || raw || waw);

    // The older goes to lane 1 when it needs lane 1 itself, or when the
    // younger needs lane 0.
    assign swap = (&valid) && !conflict && (mem0 || ctrl1);

    assign single_lane = {mem1, mem0};

    // Payload fields do not influence steering; fold them so that every
    // input bit is consumed.
    logic unused_payload;
    assign unused_payload = ^{slot0, slot1};

endmodule

// File: rtl/issue_steer.sv
// Dual-issue steering and ID/EX pipeline register.
// Takes an in-order pair of decoded instructions, steers each to the lane
// able to execute it (lane 0: ALU/branch/jump, lane 1: ALU/load/store) and
// registers the result. Pairs that cannot issue together are split over
// two cycles, holding the younger instruction and back-pressuring decode.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid_i[1:0]       - slot valids, bit 0 is the older slot
//   slot0_i, slot1_i      - decoded bundles, slot0 older
//   in_ready_o            - input pair consumed this cycle
//   ex_stall_i            - execute cannot accept; everything holds
//   flush_i               - drop in-flight, held and incoming work
//   ex0_o, ex1_o          - registered lane bundles
//   ex0_valid_o, ex1_valid_o - lane valids
//   lane1_older_o         - both lanes valid and lane 1 is older
module issue_steer
    import issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in_valid_i,
    input  id_bundle_t slot0_i,
    input  id_bundle_t slot1_i,
    output logic       in_ready_o,
    input  logic       ex_stall_i,
    input  logic       flush_i,
    output id_bundle_t ex0_o,
    output id_bundle_t ex1_o,
    output logic       ex0_valid_o,
    output logic       ex1_valid_o,
    output logic       lane1_older_o
);

    // The bundle layout is fixed by the package; refuse any other width.
    if (XLEN != ISSUE_XLEN) begin : g_xlen_check
        $error("issue_steer: XLEN must equal issue_pkg::ISSUE_XLEN");
    end

    steer_state_t state;
    id_bundle_t   hold_q;
    logic         hold_valid;

    logic         conflict, swap;
    logic [1:0]   single_lane;

    // Single-issue candidate: held instruction in SPLIT, otherwise the only
    // valid slot (slot 1 alone for 2'b10), or the older half of a split.
    id_bundle_t   one_bundle;
    logic         one_lane;
    logic         one_valid;
    logic         pair_issue;

    pair_check u_pair_check (
        .slot0       (slot0_i),
        .slot1       (slot1_i),
        .valid       (in_valid_i),
        .conflict    (conflict),
        .swap        (swap),
        .single_lane (single_lane)
    );

    assign in_ready_o = !rst && !ex_stall_i && (state == ST_PAIR);
    assign pair_issue = (state == ST_PAIR) && (&in_valid_i) && !conflict;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        one_bundle = slot0_i;
        one_lane   = single_lane[0];
        one_valid  = |in_valid_i;
        if (state == ST_SPLIT) begin
            one_bundle = hold_q;
            one_lane   = is_mem(hold_q);
            one_valid  = hold_valid;
        end else if (in_valid_i == 2'b10) begin
            one_bundle = slot1_i;
            one_lane   = single_lane[1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_PAIR;
            hold_valid    <= 1'b0;
            ex0_o         <= '0;
            ex1_o         <= '0;
            ex0_valid_o   <= 1'b0;
            ex1_valid_o   <= 1'b0;
            lane1_older_o <= 1'b0;
        end else if (flush_i) begin
            state         <= ST_PAIR;
            hold_valid    <= 1'b0;
            ex0_valid_o   <= 1'b0;
            ex1_valid_o   <= 1'b0;
            lane1_older_o <= 1'b0;
        end else if (!ex_stall_i) begin
            if (pair_issue) begin
                ex0_o         <= swap ? slot1_i : slot0_i;
                ex1_o         <= swap ? slot0_i : slot1_i;
                ex0_valid_o   <= 1'b1;
                ex1_valid_o   <= 1'b1;
                lane1_older_o <= swap;
            end else begin
                if (one_valid) begin
                    if (one_lane) ex1_o <= one_bundle;
                    else          ex0_o <= one_bundle;
                end
                ex0_valid_o   <= one_valid && !one_lane;
                ex1_valid_o   <= one_valid && one_lane;
                lane1_older_o <= 1'b0;
            end

            case (state)
                ST_PAIR: begin
                    if (conflict) begin
                        hold_valid <= 1'b1;
                        state      <= ST_SPLIT;
                    end
                end
                ST_SPLIT: begin
                    hold_valid <= 1'b0;
                    state      <= ST_PAIR;
                end
                default: state <= ST_PAIR;
            endcase
        end
    end

    // NOTE: the held payload has no reset; hold_valid alone says whether it
    // means anything, so the wide register needs no reset network.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && !ex_stall_i && (state == ST_PAIR) && conflict) begin
            hold_q <= slot1_i;
        end
    end

endmodule

// File: tb/tb_issue_steer.sv
// Self-checking bench for issue_steer: directed cases from the test plan
// followed by randomized traffic, compared against a queue-based model.
module tb_issue_steer;
    import issue_pkg::*;

    localparam int K_ALU = 0, K_ADDI = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JAL = 5;

    logic       clk = 1'b0;
    logic       rst, ex_stall_i, flush_i;
    logic [1:0] in_valid_i;
    id_bundle_t slot0_i, slot1_i;
    logic       in_ready_o;
    id_bundle_t ex0_o, ex1_o;
    logic       ex0_valid_o, ex1_valid_o, lane1_older_o;

    always #5 clk = ~clk;

    issue_steer #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .slot0_i       (slot0_i),
        .slot1_i       (slot1_i),
        .in_ready_o    (in_ready_o),
        .ex_stall_i    (ex_stall_i),
        .flush_i       (flush_i),
        .ex0_o         (ex0_o),
        .ex1_o         (ex1_o),
        .ex0_valid_o   (ex0_valid_o),
        .ex1_valid_o   (ex1_valid_o),
        .lane1_older_o (lane1_older_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected lane contents plus a queue of instructions that were accepted
    // but not yet issued (the deferred younger half of a split pair).
    logic       m_v0, m_v1, m_older;
    id_bundle_t m_b0, m_b1;
    bit         m_zero;
    id_bundle_t pend[$];

    function automatic bit f_mem(input id_bundle_t x);
        return x.opcode == 7'b0000011 || x.opcode == 7'b0100011;
    endfunction

    function automatic bit f_ctrl(input id_bundle_t x);
        return x.Jump || x.Branch;
    endfunction

    function automatic bit f_conflict(input id_bundle_t o, input id_bundle_t y);
        bit writes_o = o.RegWrite && o.Rd != 0;
        if (f_mem(o) && f_mem(y))   return 1;
        if (f_ctrl(o) && f_ctrl(y)) return 1;
        if (writes_o && (y.RS1 == o.Rd || y.RS2 == o.Rd)) return 1;
        if (writes_o && y.RegWrite && y.Rd == o.Rd) return 1;
        return 0;
    endfunction

    task automatic model_one(input id_bundle_t x);
        m_older = 0;
        if (f_mem(x)) begin m_b1 = x; m_v1 = 1; m_v0 = 0; end
        else          begin m_b0 = x; m_v0 = 1; m_v1 = 0; end
    endtask

    function automatic id_bundle_t mk(input int kind, input int rd, input int rs1, input int rs2);
        id_bundle_t x;
        x.RD1        = $urandom;
        x.RD2        = $urandom;
        x.Extimm     = $urandom;
        x.PC         = $urandom;
        x.PCPlus4    = $urandom;
        x.ResultSrc  = 2'($urandom_range(0, 3));
        x.MemWrite   = 3'($urandom_range(0, 7));
        x.MemRead    = 3'($urandom_range(0, 7));
        x.AluControl = 5'($urandom_range(0, 31));
        x.mux2       = 1'($urandom_range(0, 1));
        x.mux3       = 1'($urandom_range(0, 1));
        x.mux4       = 1'($urandom_range(0, 1));
        x.Rd         = 5'(rd);
        x.RS1        = 5'(rs1);
        x.RS2        = 5'(rs2);
        x.Jump       = 1'b0;
        x.Branch     = 1'b0;
        x.RegWrite   = 1'b1;
        case (kind)
            K_ALU:   x.opcode = 7'b0110011;
            K_ADDI:  x.opcode = 7'b0010011;
            K_LOAD:  x.opcode = 7'b0000011;
            K_STORE: begin x.opcode = 7'b0100011; x.RegWrite = 1'b0; end
            K_BR:    begin x.opcode = 7'b1100011; x.RegWrite = 1'b0; x.Branch = 1'b1; end
            default: begin x.opcode = 7'b1101111; x.Jump = 1'b1; end
        endcase
        return x;
    endfunction

    function automatic id_bundle_t rnd_instr();
        return mk($urandom_range(0, 5), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
    endfunction

    // One clock: drive inputs after the falling edge, check ready, advance
    // the model, then check the registered outputs just after the rising edge.
    task automatic cycle(input bit r, input bit f, input bit s, input logic [1:0] v,
                         input id_bundle_t a, input id_bundle_t b);
        id_bundle_t q[$];
        @(negedge clk);
        rst = r; flush_i = f; ex_stall_i = s; in_valid_i = v; slot0_i = a; slot1_i = b;
        #1;
        check("in_ready", 256'(in_ready_o), 256'(!r && !s && pend.size() == 0));
        if (r) begin
            pend.delete();
            m_v0 = 0; m_v1 = 0; m_older = 0; m_b0 = '0; m_b1 = '0; m_zero = 1;
        end else if (f) begin
            pend.delete();
            m_v0 = 0; m_v1 = 0; m_older = 0;
        end else if (!s) begin
            m_zero = 0;
            if (pend.size() != 0) begin
                model_one(pend.pop_front());
            end else begin
                if (v[0]) q.push_back(a);
                if (v[1]) q.push_back(b);
                if (q.size() == 0) begin
                    m_v0 = 0; m_v1 = 0; m_older = 0;
                end else if (q.size() == 1) begin
                    model_one(q[0]);
                end else if (f_conflict(q[0], q[1])) begin
                    model_one(q[0]);
                    pend.push_back(q[1]);
                end else if (f_mem(q[0]) || f_ctrl(q[1])) begin
                    m_b1 = q[0]; m_b0 = q[1]; m_v0 = 1; m_v1 = 1; m_older = 1;
                end else begin
                    m_b0 = q[0]; m_b1 = q[1]; m_v0 = 1; m_v1 = 1; m_older = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        check("ex0_valid", 256'(ex0_valid_o), 256'(m_v0));
        check("ex1_valid", 256'(ex1_valid_o), 256'(m_v1));
        check("lane1_older", 256'(lane1_older_o), 256'(m_older));
        if (m_v0 || m_zero) check("ex0_bundle", 256'(ex0_o), 256'(m_b0));
        if (m_v1 || m_zero) check("ex1_bundle", 256'(ex1_o), 256'(m_b1));
    endtask

    initial begin
        id_bundle_t lw, sw, nop;
        rst = 1'b1; ex_stall_i = 1'b0; flush_i = 1'b0; in_valid_i = 2'b00;
        slot0_i = '0; slot1_i = '0;
        m_v0 = 0; m_v1 = 0; m_older = 0; m_b0 = '0; m_b1 = '0; m_zero = 1;
        nop = mk(K_ALU, 0, 0, 0);

        // Reset, with a pair offered that must not be taken.
        cycle(1, 0, 0, 2'b00, nop, nop);
        cycle(1, 0, 0, 2'b11, mk(K_ALU, 1, 2, 3), mk(K_ALU, 2, 4, 5));

        // ADD x1 + SUB x2: independent pair, no swap.
        cycle(0, 0, 0, 2'b11, mk(K_ALU, 1, 2, 3), mk(K_ALU, 2, 4, 5));
        // LW x5 + ADDI x6: swap.
        cycle(0, 0, 0, 2'b11, mk(K_LOAD, 5, 1, 0), mk(K_ADDI, 6, 1, 0));
        // LW x5 + SW: split over two cycles, both on lane 1.
        lw = mk(K_LOAD, 5, 1, 0);
        sw = mk(K_STORE, 0, 8, 9);
        cycle(0, 0, 0, 2'b11, lw, sw);
        cycle(0, 0, 0, 2'b11, nop, nop);
        cycle(0, 0, 0, 2'b00, nop, nop);
        // RAW, WAW split; double write to x0 does not.
        cycle(0, 0, 0, 2'b11, mk(K_ADDI, 3, 1, 0), mk(K_ALU, 4, 3, 2));
        cycle(0, 0, 0, 2'b00, nop, nop);
        cycle(0, 0, 0, 2'b11, mk(K_ADDI, 3, 1, 0), mk(K_ADDI, 3, 2, 0));
        cycle(0, 0, 0, 2'b00, nop, nop);
        cycle(0, 0, 0, 2'b11, mk(K_ADDI, 0, 1, 0), mk(K_ADDI, 0, 2, 0));
        // BEQ + JAL: split; ADD + JAL: swap.
        cycle(0, 0, 0, 2'b11, mk(K_BR, 0, 1, 2), mk(K_JAL, 1, 0, 0));
        cycle(0, 0, 0, 2'b00, nop, nop);
        cycle(0, 0, 0, 2'b11, mk(K_ALU, 7, 2, 3), mk(K_JAL, 1, 0, 0));
        // Single-slot issue, including slot 1 alone.
        cycle(0, 0, 0, 2'b01, mk(K_STORE, 0, 1, 2), nop);
        cycle(0, 0, 0, 2'b10, nop, mk(K_LOAD, 9, 1, 0));
        cycle(0, 0, 0, 2'b10, nop, mk(K_ALU, 9, 1, 2));
        // Split frozen by a three-cycle stall, then the SW issues.
        cycle(0, 0, 0, 2'b11, lw, sw);
        repeat (3) cycle(0, 0, 1, 2'b11, nop, nop);
        cycle(0, 0, 0, 2'b00, nop, nop);
        cycle(0, 0, 0, 2'b00, nop, nop);
        // Flush in SPLIT: held SW is lost.
        cycle(0, 0, 0, 2'b11, lw, sw);
        cycle(0, 1, 0, 2'b11, nop, nop);
        cycle(0, 0, 0, 2'b00, nop, nop);
        // Reset in SPLIT.
        cycle(0, 0, 0, 2'b11, lw, sw);
        cycle(1, 0, 0, 2'b00, nop, nop);
        cycle(0, 0, 0, 2'b00, nop, nop);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 20, 2'($urandom_range(0, 3)),
                  rnd_instr(), rnd_instr());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
